// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one data memory between the core load/store
// path and a debug/loader port, holding memory controls for LAT cycles per access.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LAT    = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              c_req,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              owner;     // 0 = core, 1 = debug
    logic              last_gnt;  // 0 = core, 1 = debug
    logic              sel_d;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        sel_d     = d_req & (~c_req | ~last_gnt);
        sel_write = sel_d ? d_write : c_write;
        sel_addr  = sel_d ? d_addr  : c_addr;
        sel_wdata = sel_d ? d_wdata : c_wdata;
    end

    // The m_* registers double as the latched request for the whole access window.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            m_read   <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            c_ack    <= 1'b0;
            d_ack    <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
            busy     <= 1'b0;
        end else begin
            c_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (c_req | d_req) begin
                        owner   <= sel_d;
                        m_write <= sel_write;
                        m_read  <= ~sel_write;
                        m_addr  <= sel_addr;
                        m_wdata <= sel_wdata;
                        cnt     <= 4'(LAT - 1);
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (m_read) begin
                            if (owner) d_rdata <= m_rdata;
                            else       c_rdata <= m_rdata;
                        end
                        if (owner) d_ack <= 1'b1;
                        else       c_ack <= 1'b1;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        m_addr  <= '0;
                        m_wdata <= '0;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    last_gnt <= owner;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: LAT=2 main instance plus a LAT=1 instance.
module tb_dmem_arbiter;

    typedef struct {
        bit          port;   // 0 = core, 1 = debug
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        c_req, c_write, d_req, d_write;
    logic [63:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_ack, d_ack, m_read, m_write, busy;
    logic [63:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    logic        c1_req;
    logic        c1_ack, d1_ack, m1_read, m1_write, busy1;
    logic [63:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;

    logic [63:0] mem [0:31];
    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign m_rdata  = mem[m_addr[7:3]];
    assign m1_rdata = mem[m1_addr[7:3]];
    always @(posedge CLK) if (m_write) mem[m_addr[7:3]] = m_wdata;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(2)) dut (
        .CLK(CLK), .Reset(Reset),
        .c_req(c_req), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(1)) dut1 (
        .CLK(CLK), .Reset(Reset),
        .c_req(c1_req), .c_write(1'b0), .c_addr(64'h10), .c_wdata(64'h0),
        .c_ack(c1_ack), .c_rdata(c1_rdata),
        .d_req(1'b0), .d_write(1'b0), .d_addr(64'h0), .d_wdata(64'h0),
        .d_ack(d1_ack), .d_rdata(d1_rdata),
        .m_read(m1_read), .m_write(m1_write), .m_addr(m1_addr), .m_wdata(m1_wdata),
        .m_rdata(m1_rdata), .busy(busy1)
    );

    task automatic apply_reset();
        Reset = 1'b1;
        c_req = 0; c_write = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        c1_req = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({c_ack, d_ack, m_read, m_write, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=00000", {c_ack, d_ack, m_read, m_write, busy});
        end
        n_vec++;
        if ({c_rdata, d_rdata, m_addr, m_wdata} !== 256'b0) begin
            n_err++;
            $display("FAIL reset_data c_rdata=%h d_rdata=%h m_addr=%h m_wdata=%h want all 0",
                     c_rdata, d_rdata, m_addr, m_wdata);
        end
        Reset = 1'b0;
    endtask

    task automatic test_core_load();
        exp_t e;
        int t0;
        mem[2] = 64'hDEAD_BEEF;
        @(posedge CLK); #1;
        t0 = cyc;
        c_req = 1; c_write = 0; c_addr = 64'h10; c_wdata = 64'hFFFF;
        sb_q.push_back('{1'b0, 64'hDEAD_BEEF, t0 + 3});
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k == 1) c_addr = 64'hBAD0;
            n_vec++;
            if (m_read !== 1'(k == 1 || k == 2)) begin
                n_err++; $display("FAIL load_m_read k=%0d got=%b", k, m_read);
            end
            n_vec++;
            if (m_addr !== ((k == 1 || k == 2) ? 64'h10 : 64'h0)) begin
                n_err++; $display("FAIL load_m_addr k=%0d got=%h", k, m_addr);
            end
            n_vec++;
            if (busy !== 1'(k >= 1 && k <= 3)) begin
                n_err++; $display("FAIL load_busy k=%0d got=%b", k, busy);
            end
            if (c_ack || d_ack) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL load_extra_ack k=%0d c_ack=%b d_ack=%b want none", k, c_ack, d_ack);
                end else begin
                    e = sb_q.pop_front();
                    if (d_ack !== e.port || c_ack === e.port || cyc != e.cyc || c_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL load_ack c_ack=%b d_ack=%b cyc=%0d rdata=%h want port=%0d cyc=%0d rdata=%h",
                                 c_ack, d_ack, cyc, c_rdata, e.port, e.cyc, e.data);
                    end
                end
                c_req = 0;
            end
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL load_missing_ack got=%0d pending want=0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_store_then_load();
        exp_t e;
        int t0;
        int nwr = 0;
        logic [63:0] prev = d_rdata;
        @(posedge CLK); #1;
        t0 = cyc;
        d_req = 1; d_write = 1; d_addr = 64'h20; d_wdata = 64'h1234;
        sb_q.push_back('{1'b1, prev, t0 + 3});
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (m_write) begin
                nwr++;
                n_vec++;
                if (m_addr !== 64'h20 || m_wdata !== 64'h1234 || m_read !== 1'b0) begin
                    n_err++;
                    $display("FAIL store_bus addr=%h wdata=%h rd=%b want 20/1234/0", m_addr, m_wdata, m_read);
                end
            end
            if (c_ack || d_ack) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL store_extra_ack c_ack=%b d_ack=%b want none", c_ack, d_ack);
                end else begin
                    e = sb_q.pop_front();
                    if (d_ack !== 1'b1 || c_ack !== 1'b0 || cyc != e.cyc || d_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL store_ack d_ack=%b cyc=%0d d_rdata=%h want cyc=%0d d_rdata=%h",
                                 d_ack, cyc, d_rdata, e.cyc, e.data);
                    end
                end
                d_req = 0;
            end
        end
        n_vec++;
        if (nwr != 2 || sb_q.size() != 0) begin
            n_err++; $display("FAIL store_window writes=%0d pending=%0d want 2/0", nwr, sb_q.size());
        end
        n_vec++;
        if (mem[4] !== 64'h1234) begin
            n_err++; $display("FAIL store_mem got=%h want=1234", mem[4]);
        end
        sb_q.delete();

        @(posedge CLK); #1;
        t0 = cyc;
        c_req = 1; c_write = 0; c_addr = 64'h20;
        sb_q.push_back('{1'b0, 64'h1234, t0 + 3});
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (c_ack || d_ack) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL reload_extra_ack c_ack=%b d_ack=%b want none", c_ack, d_ack);
                end else begin
                    e = sb_q.pop_front();
                    if (c_ack !== 1'b1 || d_ack !== 1'b0 || cyc != e.cyc || c_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL reload_ack c_ack=%b cyc=%0d c_rdata=%h want cyc=%0d c_rdata=%h",
                                 c_ack, cyc, c_rdata, e.cyc, e.data);
                    end
                end
                c_req = 0;
            end
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL reload_missing_ack got=%0d pending want=0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_access();
        @(posedge CLK); #1;
        c_req = 1; c_write = 0; c_addr = 64'h18;
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        #1;
        n_vec++;
        if ({c_ack, d_ack, m_read, m_write, busy} !== 5'b0 ||
            {c_rdata, d_rdata, m_addr, m_wdata} !== 256'b0) begin
            n_err++;
            $display("FAIL midreset_outputs ctrl=%b c_rdata=%h m_addr=%h want all 0",
                     {c_ack, d_ack, m_read, m_write, busy}, c_rdata, m_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_vec++;
            if (c_ack !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL midreset_hold k=%0d c_ack=%b busy=%b want 0/0", k, c_ack, busy);
            end
        end
        c_req = 0;
        Reset = 1'b0;
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int t0;
        mem[3] = 64'h5555_AAAA_0000_1111;
        @(posedge CLK); #1;
        t0 = cyc;
        c_req = 1; c_write = 0; c_addr = 64'h10;
        d_req = 1; d_write = 0; d_addr = 64'h18;
        sb_q.push_back('{1'b0, 64'hDEAD_BEEF, t0 + 3});
        sb_q.push_back('{1'b1, 64'h5555_AAAA_0000_1111, t0 + 7});
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (c_ack || d_ack) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL tie_extra_ack c_ack=%b d_ack=%b want none", c_ack, d_ack);
                end else begin
                    e = sb_q.pop_front();
                    if (d_ack !== e.port || c_ack === e.port || cyc != e.cyc ||
                        (e.port ? d_rdata : c_rdata) !== e.data) begin
                        n_err++;
                        $display("FAIL tie_ack c_ack=%b d_ack=%b cyc=%0d want port=%0d cyc=%0d data=%h",
                                 c_ack, d_ack, cyc, e.port, e.cyc, e.data);
                    end
                end
                if (c_ack) c_req = 0;
                if (d_ack) d_req = 0;
            end
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL tie_missing_ack got=%0d pending want=0", sb_q.size());
        end
        c_req = 0; d_req = 0;
        sb_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int t0;
        @(posedge CLK); #1;
        t0 = cyc;
        c_req = 1; c_write = 0; c_addr = 64'h10;
        d_req = 1; d_write = 0; d_addr = 64'h18;
        for (int i = 0; i < 6; i++)
            sb_q.push_back('{1'(i % 2), (i % 2) ? 64'h5555_AAAA_0000_1111 : 64'hDEAD_BEEF, t0 + 3 + 4 * i});
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            if (c_ack || d_ack) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_ack c_ack=%b d_ack=%b want none", c_ack, d_ack);
                end else begin
                    e = sb_q.pop_front();
                    if (d_ack !== e.port || c_ack === e.port || cyc != e.cyc ||
                        (e.port ? d_rdata : c_rdata) !== e.data) begin
                        n_err++;
                        $display("FAIL b2b_ack c_ack=%b d_ack=%b cyc=%0d want port=%0d cyc=%0d data=%h",
                                 c_ack, d_ack, cyc, e.port, e.cyc, e.data);
                    end
                end
                if (sb_q.size() == 0) begin
                    c_req = 0; d_req = 0;
                end
            end
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL b2b_missing_ack got=%0d pending want=0", sb_q.size());
        end
        c_req = 0; d_req = 0;
        sb_q.delete();
    endtask

    task automatic test_lat1_drop();
        exp_t e;
        int t0;
        @(posedge CLK); #1;
        t0 = cyc;
        c1_req = 1;
        sb_q.push_back('{1'b0, 64'hDEAD_BEEF, t0 + 2});
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (k == 1) c1_req = 0;
            n_vec++;
            if (m1_read !== 1'(k == 1) || busy1 !== 1'(k == 1 || k == 2) || d1_ack !== 1'b0) begin
                n_err++;
                $display("FAIL lat1_ctrl k=%0d m_read=%b busy=%b d_ack=%b", k, m1_read, busy1, d1_ack);
            end
            if (c1_ack) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL lat1_extra_ack k=%0d c_ack=1 want none", k);
                end else begin
                    e = sb_q.pop_front();
                    if (cyc != e.cyc || c1_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL lat1_ack cyc=%0d rdata=%h want cyc=%0d rdata=%h",
                                 cyc, c1_rdata, e.cyc, e.data);
                    end
                end
            end
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL lat1_missing_ack got=%0d pending want=0", sb_q.size());
        end
        sb_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'(i) * 64'h0101_0101;
        test_reset();
        test_core_load();
        test_store_then_load();
        test_reset_mid_access();
        test_simultaneous();
        test_back_to_back();
        test_lat1_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
